// File: rtl/pht_predictor.sv
// Pattern-history-table branch predictor.
// 2^IDX_W saturating counters indexed by PC bits, optionally XORed with a
// global history register (gshare). One-cycle registered prediction, one
// update per cycle with same-cycle forwarding, and a post-reset init sweep
// that fills the table so the array itself needs no reset.
module pht_predictor #(
  parameter int unsigned      IDX_W    = 10,
  parameter int unsigned      CNT_W    = 3,
  parameter int unsigned      HIST_W   = 8,
  parameter bit               GSHARE   = 1'b1,
  parameter logic [CNT_W-1:0] INIT_CNT = {1'b1, {(CNT_W-1){1'b0}}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pred_valid,
  input  logic [IDX_W-1:0]  pred_addr,
  output logic              predict,
  output logic [IDX_W-1:0]  pred_index,
  output logic              pred_out_valid,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_index,
  input  logic              upd_taken,
  output logic              init_busy,
  output logic [HIST_W-1:0] ghr
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Counter +1, held at the top of the range.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // Counter -1, held at zero.
  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic            taken);
    return taken ? sat_inc(c) : sat_dec(c);
  endfunction

  // Shift the newest outcome into the LSB; the HIST_W+1 staging vector keeps
  // this valid for a one-bit history as well.
  function automatic logic [HIST_W-1:0] hist_shift(input logic [HIST_W-1:0] h,
                                                   input logic              t);
    logic [HIST_W:0] tmp;
    tmp = {h, t};
    return tmp[HIST_W-1:0];
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   init_ptr_q;
  logic [HIST_W-1:0]  ghr_q;
  logic [CNT_W-1:0]   table_q [DEPTH];

  logic               run;
  logic               pred_en;
  logic               upd_en;
  logic [IDX_W-1:0]   hist_ext;
  logic [IDX_W-1:0]   idx_p0;
  logic [CNT_W-1:0]   rd_cnt_p0;
  logic [CNT_W-1:0]   upd_old_p0;
  logic [CNT_W-1:0]   upd_new_p0;
  logic               fwd_p0;
  logic [CNT_W-1:0]   cnt_p0;

  logic               vld_p1;
  logic               pred_p1;
  logic [IDX_W-1:0]   idx_p1;

  assign run     = (state_q == ST_RUN);
  assign pred_en = run & pred_valid;
  assign upd_en  = run & upd_valid;

  // ---- stage p0: index formation, table read, update and forwarding ----
  assign hist_ext   = IDX_W'(ghr_q);
  assign idx_p0     = GSHARE ? (pred_addr ^ hist_ext) : pred_addr;
  assign rd_cnt_p0  = table_q[idx_p0];
  assign upd_old_p0 = table_q[upd_index];
  assign upd_new_p0 = cnt_next(upd_old_p0, upd_taken);
  assign fwd_p0     = upd_valid && (idx_p0 == upd_index);
  assign cnt_p0     = fwd_p0 ? upd_new_p0 : rd_cnt_p0;

  // Next-state logic: leave INIT once the last entry has been written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (init_ptr_q == {IDX_W{1'b1}}) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // State register, sweep pointer and global history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
      ghr_q      <= '0;
    end else begin
      state_q <= state_d;
      if (!run) init_ptr_q <= init_ptr_q + IDX_W'(1);
      if (upd_en) ghr_q <= hist_shift(ghr_q, upd_taken);
    end
  end

  // Counter array: sweep writes during INIT, branch updates during RUN.
  always_ff @(posedge clk) begin
    if (!run) begin
      table_q[init_ptr_q] <= INIT_CNT;
    end else if (upd_en) begin
      table_q[upd_index] <= upd_new_p0;
    end
  end

  // ---- stage p1: registered prediction; outputs hold when idle ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      pred_p1 <= 1'b0;
      idx_p1  <= '0;
    end else if (pred_en) begin
      vld_p1  <= 1'b1;
      pred_p1 <= cnt_p0[CNT_W-1];
      idx_p1  <= idx_p0;
    end else begin
      vld_p1  <= 1'b0;
    end
  end

  assign predict        = pred_p1;
  assign pred_index     = idx_p1;
  assign pred_out_valid = vld_p1;
  assign init_busy      = !run;
  assign ghr            = ghr_q;

endmodule

// File: tb/tb_pht_predictor.sv
// Bench for pht_predictor: a default gshare instance and a small bimodal
// instance (IDX_W=4, CNT_W=2, HIST_W=4) sharing clock and reset.
module tb_pht_predictor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       g_pv, g_uv, g_tk;
  logic [9:0] g_addr, g_uidx;
  logic       g_pred, g_pov, g_busy;
  logic [9:0] g_pidx;
  logic [7:0] g_ghr;

  logic       b_pv, b_uv, b_tk;
  logic [3:0] b_addr, b_uidx;
  logic       b_pred, b_pov, b_busy;
  logic [3:0] b_pidx;
  logic [3:0] b_ghr;

  pht_predictor u_gs (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(g_pv), .pred_addr(g_addr),
    .predict(g_pred), .pred_index(g_pidx), .pred_out_valid(g_pov),
    .upd_valid(g_uv), .upd_index(g_uidx), .upd_taken(g_tk),
    .init_busy(g_busy), .ghr(g_ghr)
  );

  pht_predictor #(.IDX_W(4), .CNT_W(2), .HIST_W(4), .GSHARE(1'b0)) u_bm (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(b_pv), .pred_addr(b_addr),
    .predict(b_pred), .pred_index(b_pidx), .pred_out_valid(b_pov),
    .upd_valid(b_uv), .upd_index(b_uidx), .upd_taken(b_tk),
    .init_busy(b_busy), .ghr(b_ghr)
  );

  typedef struct {
    bit pv; int addr; bit uv; int uidx; bit tk;
    bit e_pov; bit e_pred; int e_pidx; int e_ghr;
  } vec_t;

  vec_t gv[8];
  vec_t bv[14];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model for the gshare instance: counters as plain integers.
  int m_cnt[1024];
  int m_ghr, m_pov, m_pred, m_pidx;

  bit sat_tk[17] = '{0,0,0,0,0, 1,1,1,1,1,1,1,1, 0,0,0,0};
  bit sat_ep[17] = '{0,0,0,0,0, 0,0,0,1,1,1,1,1, 1,1,1,0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 1024; i++) m_cnt[i] = 4;
    m_ghr = 0; m_pov = 0; m_pred = 0; m_pidx = 0;
  endfunction

  task automatic g_step(input bit pv, input int addr, input bit uv, input int uidx, input bit tk);
    int idx;
    g_pv = pv; g_addr = addr[9:0]; g_uv = uv; g_uidx = uidx[9:0]; g_tk = tk;
    idx = (addr ^ m_ghr) & 1023;
    if (uv) begin
      if (tk) m_cnt[uidx] = (m_cnt[uidx] < 7) ? m_cnt[uidx] + 1 : 7;
      else    m_cnt[uidx] = (m_cnt[uidx] > 0) ? m_cnt[uidx] - 1 : 0;
      m_ghr = ((m_ghr << 1) | int'(tk)) & 255;
    end
    if (pv) begin
      m_pov = 1; m_pred = (m_cnt[idx] >= 4) ? 1 : 0; m_pidx = idx;
    end else begin
      m_pov = 0;
    end
    tick();
    g_pv = 1'b0; g_uv = 1'b0;
  endtask

  task automatic g_check_model(input string tag);
    check({tag, "_pov"},  32'(g_pov),  32'(m_pov));
    check({tag, "_pred"}, 32'(g_pred), 32'(m_pred));
    check({tag, "_pidx"}, 32'(g_pidx), 32'(m_pidx));
    check({tag, "_ghr"},  32'(g_ghr),  32'(m_ghr));
  endtask

  task automatic g_random(input int n, input string tag);
    bit pv, uv, tk;
    int t, addr, uidx;
    for (int k = 0; k < n; k++) begin
      pv   = ($urandom_range(0, 3) != 0);
      t    = int'($urandom_range(0, 15));
      addr = ($urandom_range(0, 1) == 1) ? (t ^ m_ghr) : int'($urandom_range(0, 1023));
      uv   = ($urandom_range(0, 2) != 0);
      uidx = ($urandom_range(0, 3) == 0) ? ((addr ^ m_ghr) & 1023) : int'($urandom_range(0, 15));
      tk   = 1'($urandom);
      g_step(pv, addr, uv, uidx, tk);
      g_check_model(tag);
    end
  endtask

  // Drive garbage into the gshare instance until its sweep ends.
  task automatic sweep(output int cg, output int cb, output int bad);
    cg = 0; cb = 0; bad = 0;
    while (g_busy === 1'b1 && cg < 2000) begin
      g_pv = 1'($urandom); g_addr = 10'($urandom); g_uv = 1'($urandom);
      g_uidx = 10'($urandom); g_tk = 1'($urandom);
      tick();
      cg++;
      if (cb == 0 && b_busy === 1'b0) cb = cg;
      if (g_pov !== 1'b0 || g_ghr !== 8'h00) bad++;
    end
    g_pv = 1'b0; g_uv = 1'b0;
  endtask

  task automatic b_step(input vec_t v);
    b_pv = v.pv; b_addr = 4'(v.addr); b_uv = v.uv; b_uidx = 4'(v.uidx); b_tk = v.tk;
    tick();
    b_pv = 1'b0; b_uv = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cg, cb, bad, a;

    // Table: gshare instance, starting from all counters 4 and ghr 0.
    gv[0] = '{1'b1, 'h000, 1'b0, 0,    1'b0, 1'b1, 1'b1, 'h000, 'h00};
    gv[1] = '{1'b0, 'h000, 1'b1, 3,    1'b1, 1'b0, 1'b1, 'h000, 'h01};
    gv[2] = '{1'b1, 'h002, 1'b0, 0,    1'b0, 1'b1, 1'b1, 'h003, 'h01};
    gv[3] = '{1'b1, 'h010, 1'b1, 'h20, 1'b0, 1'b1, 1'b1, 'h011, 'h02};
    gv[4] = '{1'b1, 'h00B, 1'b1, 9,    1'b0, 1'b1, 1'b0, 'h009, 'h04};
    gv[5] = '{1'b1, 'h024, 1'b0, 0,    1'b0, 1'b1, 1'b0, 'h020, 'h04};
    gv[6] = '{1'b0, 'h000, 1'b0, 0,    1'b0, 1'b0, 1'b0, 'h020, 'h04};
    gv[7] = '{1'b1, 'h00D, 1'b1, 9,    1'b1, 1'b1, 1'b1, 'h009, 'h09};

    // Table: bimodal instance, counters start at 2, history never indexes.
    bv[0]  = '{1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 0, 0};
    bv[1]  = '{1'b1, 0, 1'b1, 0, 1'b1, 1'b1, 1'b1, 0, 1};
    bv[2]  = '{1'b1, 0, 1'b1, 0, 1'b1, 1'b1, 1'b1, 0, 3};
    bv[3]  = '{1'b1, 0, 1'b1, 0, 1'b0, 1'b1, 1'b1, 0, 6};
    bv[4]  = '{1'b1, 5, 1'b0, 0, 1'b0, 1'b1, 1'b1, 5, 6};
    bv[5]  = '{1'b1, 0, 1'b1, 0, 1'b1, 1'b1, 1'b1, 0, 13};
    bv[6]  = '{1'b1, 0, 1'b1, 0, 1'b1, 1'b1, 1'b1, 0, 11};
    bv[7]  = '{1'b1, 0, 1'b1, 0, 1'b1, 1'b1, 1'b1, 0, 7};
    bv[8]  = '{1'b1, 0, 1'b1, 0, 1'b0, 1'b1, 1'b1, 0, 14};
    bv[9]  = '{1'b1, 0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 0, 12};
    bv[10] = '{1'b0, 9, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 12};
    bv[11] = '{1'b1, 0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 0, 8};
    bv[12] = '{1'b1, 0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 0, 0};
    bv[13] = '{1'b1, 0, 1'b1, 0, 1'b1, 1'b1, 1'b0, 0, 1};

    g_pv = 0; g_addr = 0; g_uv = 0; g_uidx = 0; g_tk = 0;
    b_pv = 0; b_addr = 0; b_uv = 0; b_uidx = 0; b_tk = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy",   32'(g_busy), 1);
    check("rst_ghr",    32'(g_ghr),  0);
    check("rst_pov",    32'(g_pov),  0);
    check("rst_pred",   32'(g_pred), 0);
    check("rst_pidx",   32'(g_pidx), 0);
    check("rst_busy_b", 32'(b_busy), 1);
    tick();
    tick();
    rst_n = 1'b1;

    sweep(cg, cb, bad);
    check("sweep_len",    32'(cg),  1024);
    check("sweep_len_b",  32'(cb),  16);
    check("init_ignored", 32'(bad), 0);

    // First RUN cycle request at an arbitrary address.
    model_reset();
    a = int'($urandom_range(0, 1023));
    g_step(1'b1, a, 1'b0, 0, 1'b0);
    check("first_pov",  32'(g_pov),  1);
    check("first_pred", 32'(g_pred), 1);
    check("first_pidx", 32'(g_pidx), 32'(a));

    for (int i = 0; i < 8; i++) begin
      g_step(gv[i].pv, gv[i].addr, gv[i].uv, gv[i].uidx, gv[i].tk);
      check($sformatf("gvec%0d_pov", i),  32'(g_pov),  32'(gv[i].e_pov));
      check($sformatf("gvec%0d_pred", i), 32'(g_pred), 32'(gv[i].e_pred));
      check($sformatf("gvec%0d_pidx", i), 32'(g_pidx), 32'(gv[i].e_pidx));
      check($sformatf("gvec%0d_ghr", i),  32'(g_ghr),  32'(gv[i].e_ghr));
    end

    // Saturation on entry 5: forwarded request each step shows the new MSB.
    for (int i = 0; i < 17; i++) begin
      g_step(1'b1, 5 ^ m_ghr, 1'b1, 5, sat_tk[i]);
      check($sformatf("sat%0d_pred", i), 32'(g_pred), 32'(sat_ep[i]));
      check($sformatf("sat%0d_pidx", i), 32'(g_pidx), 5);
    end

    g_random(2000, "rand1");

    // Small bimodal instance.
    check("bm_ghr0", 32'(b_ghr), 0);
    for (int i = 0; i < 14; i++) begin
      b_step(bv[i]);
      check($sformatf("bvec%0d_pov", i),  32'(b_pov),  32'(bv[i].e_pov));
      check($sformatf("bvec%0d_pred", i), 32'(b_pred), 32'(bv[i].e_pred));
      check($sformatf("bvec%0d_pidx", i), 32'(b_pidx), 32'(bv[i].e_pidx));
      check($sformatf("bvec%0d_ghr", i),  32'(b_ghr),  32'(bv[i].e_ghr));
    end

    // Asynchronous reset from RUN with a valid prediction outstanding.
    g_step(1'b1, 1, 1'b1, 7, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("runrst_busy", 32'(g_busy), 1);
    check("runrst_ghr",  32'(g_ghr),  0);
    check("runrst_pov",  32'(g_pov),  0);
    check("runrst_pred", 32'(g_pred), 0);
    check("runrst_pidx", 32'(g_pidx), 0);
    tick();
    rst_n = 1'b1;

    // Reset again 500 entries into the sweep.
    for (int i = 0; i < 500; i++) begin
      g_pv = 1'($urandom); g_addr = 10'($urandom); g_uv = 1'($urandom);
      g_uidx = 10'($urandom); g_tk = 1'($urandom);
      tick();
    end
    g_pv = 1'b0; g_uv = 1'b0;
    check("mid_busy_before", 32'(g_busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_busy", 32'(g_busy), 1);
    check("mid_ghr",  32'(g_ghr),  0);
    check("mid_pov",  32'(g_pov),  0);
    tick();
    rst_n = 1'b1;
    sweep(cg, cb, bad);
    check("resweep_len",    32'(cg),  1024);
    check("resweep_len_b",  32'(cb),  16);
    check("resweep_ignored", 32'(bad), 0);

    model_reset();
    g_random(1500, "rand2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
